pin_collider: RTL and testbench

//  Producer side of the pin-motion interface: once per frame it scans all 10 pin positions against the ball.
//  It flags pins the ball touches (sticky) and assigns each newly hit pin a velocity derived from the ball velocity.
//  It then pulses valid so the pin-position block applies one motion step.

---
 rtl/pin_collider.sv | 163 ++++++++++++++++
 tb/tb_pin_collider.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pin_collider.sv
// Per-frame pin/ball collision scanner: one pin issued per cycle into a 2-stage
// distance pipeline, sticky hit flags with velocity captured on first hit.
module pin_collider #(
  parameter int HIT_RADIUS = 40,
  parameter int VEL_SHIFT  = 2,
  parameter int NUM_PINS   = 10
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rst_sim,
  input  logic                         frame_in,
  input  logic [10:0]                  ball_x,
  input  logic [9:0]                   ball_y,
  input  logic [15:0]                  ball_vx,
  input  logic [15:0]                  ball_vy,
  input  logic                         ball_x_neg,
  input  logic [NUM_PINS-1:0][10:0]    pins_x,
  input  logic [NUM_PINS-1:0][9:0]     pins_y,
  output logic                         valid_out,
  output logic                         is_vy_neg,
  output logic [NUM_PINS-1:0][15:0]    pins_vx_out,
  output logic [NUM_PINS-1:0][15:0]    pins_vy_out,
  output logic [NUM_PINS-1:0]          pins_hit_out,
  output logic                         busy_out
);
  localparam logic [22:0] R2   = 23'(HIT_RADIUS * HIT_RADIUS);
  localparam logic [3:0]  LAST = 4'(NUM_PINS - 1);

  typedef enum logic [2:0] {IDLE, SNAP, SCAN, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;

  logic [10:0] bx_q, bx_d;
  logic [9:0]  by_q, by_d;
  logic [15:0] bvx_q, bvx_d, bvy_q, bvy_d;
  logic        bneg_q, bneg_d;
  logic [NUM_PINS-1:0][10:0] px_q, px_d;
  logic [NUM_PINS-1:0][9:0]  py_q, py_d;

  // vld_pipe[0]: issued pin index, vld_pipe[1]: dx/dy registered
  logic [1:0]  vld_pipe_q, vld_pipe_d;
  logic [3:0]  iss_idx_q, iss_idx_d, s1_idx_q, s1_idx_d;
  logic [10:0] dx_q, dx_d, px_sel;
  logic [9:0]  dy_q, dy_d, py_sel;
  logic [21:0] dx2;
  logic [19:0] dy2;
  logic [22:0] d2;

  logic [NUM_PINS-1:0]       hit_q, hit_d;
  logic [NUM_PINS-1:0][15:0] vx_q, vx_d, vy_q, vy_d;
  logic                      neg_q, neg_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bx_d       = bx_q;
    by_d       = by_q;
    bvx_d      = bvx_q;
    bvy_d      = bvy_q;
    bneg_d     = bneg_q;
    px_d       = px_q;
    py_d       = py_q;
    hit_d      = hit_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    neg_d      = neg_q;
    iss_idx_d  = iss_idx_q;

    vld_pipe_d = {vld_pipe_q[0], state_q == SCAN};
    s1_idx_d   = iss_idx_q;
    px_sel     = px_q[iss_idx_q];
    py_sel     = py_q[iss_idx_q];
    dx_d       = (bx_q >= px_sel) ? bx_q - px_sel : px_sel - bx_q;
    dy_d       = (by_q >= py_sel) ? by_q - py_sel : py_sel - by_q;

    dx2 = {11'd0, dx_q} * {11'd0, dx_q};
    dy2 = {10'd0, dy_q} * {10'd0, dy_q};
    d2  = {1'b0, dx2} + {3'd0, dy2};

    // first hit only: later frames keep the original velocity
    if (vld_pipe_q[1] && !hit_q[s1_idx_q] && d2 <= R2) begin
      hit_d[s1_idx_q] = 1'b1;
      vx_d[s1_idx_q]  = bvx_q >> VEL_SHIFT;
      vy_d[s1_idx_q]  = bvy_q >> VEL_SHIFT;
      neg_d           = bneg_q;
    end

    case (state_q)
      IDLE: if (frame_in) begin
        bx_d    = ball_x;
        by_d    = ball_y;
        bvx_d   = ball_vx;
        bvy_d   = ball_vy;
        bneg_d  = ball_x_neg;
        px_d    = pins_x;
        py_d    = pins_y;
        state_d = SNAP;
      end
      SNAP: begin
        idx_d   = 4'd0;
        state_d = SCAN;
      end
      SCAN: begin
        iss_idx_d = idx_q;
        idx_d     = idx_q + 4'd1;
        if (idx_q == LAST) state_d = DRAIN;
      end
      DRAIN: if (vld_pipe_q[1] && s1_idx_q == LAST) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || rst_sim) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      bvx_q      <= '0;
      bvy_q      <= '0;
      bneg_q     <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      vld_pipe_q <= '0;
      iss_idx_q  <= '0;
      s1_idx_q   <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      hit_q      <= '0;
      vx_q       <= '0;
      vy_q       <= '0;
      neg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      bvx_q      <= bvx_d;
      bvy_q      <= bvy_d;
      bneg_q     <= bneg_d;
      px_q       <= px_d;
      py_q       <= py_d;
      vld_pipe_q <= vld_pipe_d;
      iss_idx_q  <= iss_idx_d;
      s1_idx_q   <= s1_idx_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      hit_q      <= hit_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      neg_q      <= neg_d;
    end
  end

  assign valid_out    = (state_q == DONE);
  assign busy_out     = (state_q != IDLE);
  assign is_vy_neg    = neg_q;
  assign pins_hit_out = hit_q;
  assign pins_vx_out  = vx_q;
  assign pins_vy_out  = vy_q;
endmodule

// File: tb/tb_pin_collider.sv
// Randomized bench for pin_collider against a per-frame distance model.
module tb_pin_collider;
  logic clk_in = 1'b0;
  logic rst_in, rst_sim, frame_in, ball_x_neg;
  logic [10:0] ball_x;
  logic [9:0]  ball_y;
  logic [15:0] ball_vx, ball_vy;
  logic [9:0][10:0] pins_x;
  logic [9:0][9:0]  pins_y;
  logic valid_out, is_vy_neg, busy_out;
  logic [9:0][15:0] pins_vx_out, pins_vy_out;
  logic [9:0] pins_hit_out;

  pin_collider dut (
    .clk_in(clk_in), .rst_in(rst_in), .rst_sim(rst_sim), .frame_in(frame_in),
    .ball_x(ball_x), .ball_y(ball_y), .ball_vx(ball_vx), .ball_vy(ball_vy),
    .ball_x_neg(ball_x_neg), .pins_x(pins_x), .pins_y(pins_y),
    .valid_out(valid_out), .is_vy_neg(is_vy_neg), .pins_vx_out(pins_vx_out),
    .pins_vy_out(pins_vy_out), .pins_hit_out(pins_hit_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_pass = 0;
  logic [9:0]       m_hit;
  logic [9:0][15:0] m_vx, m_vy;
  logic             m_neg;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_hit = '0; m_vx = '0; m_vy = '0; m_neg = 1'b0;
  endtask

  // Distance test straight from the collision rule, pins in scan order.
  task automatic model_scan(input int bx, input int by, input int vx, input int vy, input bit neg,
                            input logic [9:0][10:0] px, input logic [9:0][9:0] py);
    for (int i = 0; i < 10; i++) begin
      int dx, dy, d2;
      dx = bx - int'(px[i]); if (dx < 0) dx = -dx;
      dy = by - int'(py[i]); if (dy < 0) dy = -dy;
      d2 = dx * dx + dy * dy;
      if (!m_hit[i] && d2 <= 40 * 40) begin
        m_hit[i] = 1'b1;
        m_vx[i]  = 16'(vx / 4);
        m_vy[i]  = 16'(vy / 4);
        m_neg    = neg;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_hit"}, 160'(pins_hit_out), 160'(m_hit));
    chk({tag, "_vx"},  160'(pins_vx_out),  160'(m_vx));
    chk({tag, "_vy"},  160'(pins_vy_out),  160'(m_vy));
    chk({tag, "_neg"}, 160'(is_vy_neg),    160'(m_neg));
  endtask

  task automatic set_rack();
    for (int i = 0; i < 10; i++) begin
      pins_x[i] = 11'(300 + 30 * (i % 4));
      pins_y[i] = 10'(100 + 30 * (i / 4));
    end
  endtask

  task automatic do_reset(input bit use_sim, input string tag);
    @(negedge clk_in);
    if (use_sim) rst_sim = 1'b1; else rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0; rst_sim = 1'b0;
    model_reset();
    chk({tag, "_valid"}, 160'(valid_out), 160'(0));
    chk({tag, "_busy"},  160'(busy_out),  160'(0));
    check_outputs(tag);
  endtask

  task automatic frame(input int bx, input int by, input int vx, input int vy, input bit neg,
                       input bit mid_pulse, input bit mid_rst, input string tag);
    int first, nvalid;
    logic [9:0][10:0] px;
    logic [9:0][9:0]  py;
    @(negedge clk_in);
    ball_x = 11'(bx); ball_y = 10'(by); ball_vx = 16'(vx); ball_vy = 16'(vy);
    ball_x_neg = neg; frame_in = 1'b1;
    px = pins_x; py = pins_y;
    @(posedge clk_in); #1;
    frame_in = 1'b0;
    chk({tag, "_busy_start"}, 160'(busy_out), 160'(1));
    if (!mid_rst) model_scan(bx, by, vx, vy, neg, px, py);
    first = 0; nvalid = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk_in); #1;
      if (valid_out) begin
        nvalid++;
        if (first == 0) begin
          first = k;
          check_outputs({tag, "_atvalid"});
        end
      end
      if (k == 4) begin
        // inputs moving mid-scan must not leak into the frame
        if (mid_pulse) frame_in = 1'b1;
        if (mid_rst) rst_sim = 1'b1;
        ball_x = 11'($urandom); ball_vx = 16'($urandom); ball_x_neg = ~neg;
        pins_x[0] = 11'($urandom);
      end
      if (k == 5) begin
        frame_in = 1'b0; rst_sim = 1'b0; pins_x[0] = px[0];
      end
    end
    if (mid_rst) begin
      model_reset();
      chk({tag, "_nvalid"}, 160'(nvalid), 160'(0));
    end else begin
      chk({tag, "_latency"}, 160'(first), 160'(13));
      chk({tag, "_nvalid"}, 160'(nvalid), 160'(1));
    end
    chk({tag, "_busy_end"}, 160'(busy_out), 160'(0));
    check_outputs({tag, "_idle"});
  endtask

  initial begin
    rst_in = 1'b0; rst_sim = 1'b0; frame_in = 1'b0;
    ball_x = '0; ball_y = '0; ball_vx = '0; ball_vy = '0; ball_x_neg = 1'b0;
    set_rack();
    model_reset();

    do_reset(1'b0, "reset");
    frame(600, 500, 100, 100, 1'b0, 1'b0, 1'b0, "far");

    pins_x[0] = 11'd0; pins_y[0] = 10'd0;
    frame(0, 0, 40, 80, 1'b1, 1'b0, 1'b0, "pin0_hit");
    frame(600, 500, 400, 400, 1'b0, 1'b1, 1'b0, "sticky");

    do_reset(1'b0, "reset2");
    pins_x[0] = 11'd100; pins_y[0] = 10'd0;
    frame(124, 32, 12, 16, 1'b0, 1'b0, 1'b0, "edge_hit");
    do_reset(1'b1, "reset3");
    frame(124, 33, 12, 16, 1'b1, 1'b0, 1'b0, "edge_miss");

    frame(100, 0, 44, 88, 1'b1, 1'b0, 1'b0, "prehit");
    frame(100, 0, 44, 88, 1'b1, 1'b0, 1'b1, "abort");
    frame(100, 0, 8, 4, 1'b0, 1'b0, 1'b0, "after_abort");

    for (int n = 0; n < 40; n++) begin
      int j, bx, by;
      if (n % 6 == 0) begin
        do_reset(n % 12 == 0, "rnd_reset");
        for (int i = 0; i < 10; i++) begin
          pins_x[i] = 11'($urandom_range(0, 1279));
          pins_y[i] = 10'($urandom_range(0, 719));
        end
      end
      j  = $urandom_range(0, 9);
      bx = int'(pins_x[j]) + $urandom_range(0, 90) - 45;
      by = int'(pins_y[j]) + $urandom_range(0, 90) - 45;
      if (bx < 0) bx = 0;
      if (by < 0) by = 0;
      if (by > 1023) by = 1023;
      frame(bx, by, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
